pipeline_ctrl: RTL

Pipeline-control sequencer for the 5-stage RISC-V core. It consumes the hazard detector's `stall`, the ID-stage branch-taken decision and the data-memory handshake. It drives the write-enable, flush and bubble controls of the PC and of every pipeline register. It also tracks stall, freeze and flush cycles in saturating counters and flags protocol violations: stalls that last too long and memory requests that time out.

---
 rtl/pipeline_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline-control sequencer for the 5-stage RISC-V core
//
// Decodes one pipeline action per cycle (init, freeze, stall, branch flush,
// normal) and drives the PC / pipeline-register write, flush and bubble
// controls. It also keeps saturating stall/freeze/flush counters and sticky
// protocol-error flags.
//
// Ports:
//   clk, rst_n                      core clock, asynchronous active-low reset
//   hazard_stall, branch_taken      hazard-detector stall, ID branch taken
//   dmem_req, dmem_ready            data-memory request / completion
//   cnt_clr                         synchronous clear of the event counters
//   pc_write .. mem_wb_bubble       combinational pipeline controls
//   stall_err, mem_err              sticky error flags
//   stall_cnt, freeze_cnt, flush_cnt saturating event counters
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MAX_STALL   = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic             stall_err,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int RUN_W  = $clog2(MAX_STALL + 1) + 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_STALL);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    typedef enum logic [2:0] {
        ACT_INIT,
        ACT_FREEZE,
        ACT_STALL,
        ACT_BRANCH,
        ACT_NORMAL
    } act_t;

    state_t            state;
    act_t              act;
    logic [RUN_W-1:0]  run_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    // Action decode. In MEM_WAIT the request is held, so only dmem_ready
    // matters; the ready cycle itself already runs the S/B/N priority.
    always_comb begin
        act = ACT_NORMAL;
        case (state)
            ST_INIT: act = ACT_INIT;
            ST_RUN, ST_MEM_WAIT: begin
                if (((state == ST_RUN) && dmem_req && !dmem_ready) ||
                    ((state == ST_MEM_WAIT) && !dmem_ready))
                    act = ACT_FREEZE;
                else if (hazard_stall)
                    act = ACT_STALL;
                else if (branch_taken)
                    act = ACT_BRANCH;
                else
                    act = ACT_NORMAL;
            end
            default: act = ACT_INIT;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b0;
        case (act)
            ACT_INIT: begin
                if_id_write   = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_write   = 1'b1;
                id_ex_bubble  = 1'b1;
                ex_mem_write  = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            ACT_FREEZE: begin
                mem_wb_bubble = 1'b1;
            end
            ACT_STALL: begin
                id_ex_write  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_write = 1'b1;
            end
            ACT_BRANCH: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
            end
            default: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            run_cnt    <= '0;
            wait_cnt   <= '0;
            stall_err  <= 1'b0;
            mem_err    <= 1'b0;
            stall_cnt  <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            state <= (act == ACT_FREEZE) ? ST_MEM_WAIT : ST_RUN;

            if (cnt_clr) begin
                stall_cnt  <= '0;
                freeze_cnt <= '0;
                flush_cnt  <= '0;
            end else begin
                if (act == ACT_STALL && stall_cnt != CNT_MAX)
                    stall_cnt <= stall_cnt + 1'b1;
                if (act == ACT_FREEZE && freeze_cnt != CNT_MAX)
                    freeze_cnt <= freeze_cnt + 1'b1;
                if (act == ACT_BRANCH && flush_cnt != CNT_MAX)
                    flush_cnt <= flush_cnt + 1'b1;
            end

            // Consecutive-stall run; a freeze does not break a stall run.
            // The counter parks at MAX_STALL so it never wraps.
            case (act)
                ACT_STALL: begin
                    if (run_cnt == RUN_MAX)
                        stall_err <= 1'b1;
                    else
                        run_cnt <= run_cnt + 1'b1;
                end
                ACT_FREEZE: run_cnt <= run_cnt;
                default:    run_cnt <= '0;
            endcase

            // Every non-freeze action leads to RUN, which ends the request.
            if (act == ACT_FREEZE) begin
                if (wait_cnt != WAIT_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= WAIT_LAST)
                    mem_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule
